// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Ports: PCLK/PRESET; per-requester req_* command in, req_ready/rsp_* out; APB master P*.
module apb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : CW'(0);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]    state;
    logic [1:0]    nxt;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] win;
    logic          found;
    logic [CW-1:0] wcnt;
    logic          timeout_hit;
    logic          done;
    logic          arb;

    // Rotating priority: search starts just after the previous winner.
    always_comb begin
        int idx;
        logic [GW-1:0] j;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        j     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            j = GW'(idx);
            if (!found && req_valid[j]) begin
                found = 1'b1;
                win   = j;
            end
        end
    end

    // wcnt holds the number of earlier wait cycles, so the T-th stalled
    // ACCESS cycle is the one that completes.
    assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !PREADY
                         && (wcnt >= TLIM);
    assign done = (state == ACCESS) && (PREADY || timeout_hit);
    assign arb  = !PRESET && found && ((state == IDLE) || done);

    assign req_ready = arb ? (ONE << win) : '0;
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = arb ? SETUP : IDLE;
            SETUP:   nxt = ACCESS;
            ACCESS:  if (done) nxt = arb ? SETUP : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            wcnt       <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state     <= nxt;
            rsp_valid <= '0;
            if (arb) begin
                last_grant <= win;
                PWRITE     <= req_write[win];
                PADDR      <= req_addr[int'(win)*ADDR_W +: ADDR_W];
                PWDATA     <= req_wdata[int'(win)*DATA_W +: DATA_W];
            end
            if (state == SETUP)
                wcnt <= '0;
            else if (state == ACCESS && !PREADY && wcnt != '1)
                wcnt <= wcnt + CW'(1);
            // last_grant still names the owner of the completing transfer.
            if (done) begin
                rsp_valid <= ONE << last_grant;
                rsp_err   <= PSLVERR || timeout_hit;
                rsp_rdata <= (timeout_hit || PWRITE) ? '0 : PRDATA;
            end
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// Scoreboard bench for apb_arbiter: directed transfers, queued expected
// responses, and a monitor comparing each rsp_valid pulse.
module tb_apb_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] rd;
        logic        err;
        int          c;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nerr = 0;

    int          cfg_waits = 0;
    logic [31:0] cfg_rdata = '0;
    logic        cfg_err   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] v, input logic [31:0] rd,
                        input logic e, input int c);
        exp_t x;
        x.vld = v; x.rd = rd; x.err = e; x.c = c;
        q.push_back(x);
    endtask

    // APB slave: PREADY rises after cfg_waits stalled ACCESS cycles.
    initial begin
        int acc;
        acc = 0;
        PREADY = 1'b0;
        forever begin
            @(negedge PCLK);
            PRDATA  = cfg_rdata;
            PSLVERR = cfg_err;
            if (PSEL && PENABLE) begin
                PREADY = (acc >= cfg_waits);
                acc++;
            end else begin
                acc = 0;
                PREADY = 1'b0;
            end
        end
    end

    // Monitor: every response pulse is matched against the queue head.
    always @(negedge PCLK) begin
        exp_t x;
        if (rsp_valid != 2'b00) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
            end else begin
                x = q.pop_front();
                chk("rsp_owner", {62'd0, rsp_valid}, {62'd0, x.vld});
                chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, x.rd});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, x.err});
                chk("rsp_cycle", 64'(cyc), 64'(x.c));
            end
        end
    end

    task automatic issue(input int r, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] erd,
                         input logic eerr, input int lat, output int gc);
        bit got;
        got = 0;
        gc = -1;
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*32 +: 32]  = a;
        req_wdata[r*32 +: 32] = d;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            if (req_ready[r]) begin
                got = 1;
                gc = cyc;
                push(2'b01 << r, erd, eerr, cyc + lat);
            end
            @(negedge PCLK);
        end
        if (!got) chk("grant_timeout", 64'd0, 64'd1);
        req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (!PSEL && q.size() == 0) ok = 1;
            else @(negedge PCLK);
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int g;
        PRESET    = 1'b1;
        req_valid = 2'b11;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        #1;
        chk("rst_psel", {63'd0, PSEL}, 64'd0);
        chk("rst_penable", {63'd0, PENABLE}, 64'd0);
        chk("rst_pwrite", {63'd0, PWRITE}, 64'd0);
        chk("rst_paddr", {32'd0, PADDR}, 64'd0);
        chk("rst_pwdata", {32'd0, PWDATA}, 64'd0);
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_rsp", {31'd0, rsp_err, rsp_rdata}, 64'd0);
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        req_valid = 2'b00;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Zero-wait write from requester 0.
        cfg_waits = 0;
        issue(0, 1'b1, 32'h10, 32'hA5A5_0001, 32'h0, 1'b0, 3, g);
        chk("t1_setup_psel", {63'd0, PSEL}, 64'd1);
        chk("t1_setup_pen", {63'd0, PENABLE}, 64'd0);
        chk("t1_paddr", {32'd0, PADDR}, 64'h10);
        chk("t1_pwrite", {63'd0, PWRITE}, 64'd1);
        chk("t1_pwdata", {32'd0, PWDATA}, 64'hA5A5_0001);
        @(negedge PCLK);
        chk("t1_access_pen", {63'd0, PENABLE}, 64'd1);
        drain();

        // Read from requester 1 with three wait states.
        cfg_waits = 3;
        cfg_rdata = 32'hDEAD_BEEF;
        issue(1, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 6, g);
        for (int k = 0; k < 5; k++) begin
            chk("t2_paddr_stable", {32'd0, PADDR}, 64'h20);
            chk("t2_psel", {63'd0, PSEL}, 64'd1);
            if (k < 4) @(negedge PCLK);
        end
        drain();

        // Both requesters held: strict alternation, no IDLE gap.
        cfg_waits = 0;
        cfg_rdata = 32'h1234_5678;
        req_write = 2'b01;
        req_addr  = {32'h200, 32'h100};
        req_wdata = {32'h0, 32'h1111};
        req_valid = 2'b11;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (c > 0) chk("b2b_psel", {63'd0, PSEL}, 64'd1);
            if (c % 2 == 0) begin
                if ((c / 2) % 2 == 0) begin
                    chk("b2b_grant0", {62'd0, req_ready}, 64'd1);
                    push(2'b01, 32'h0, 1'b0, cyc + 3);
                end else begin
                    chk("b2b_grant1", {62'd0, req_ready}, 64'd2);
                    push(2'b10, 32'h1234_5678, 1'b0, cyc + 3);
                end
            end else begin
                chk("b2b_nogrant", {62'd0, req_ready}, 64'd0);
            end
            @(negedge PCLK);
        end
        req_valid = 2'b00;
        drain();

        // Slave error, then an error-free transfer clears rsp_err.
        cfg_rdata = 32'hCAFE_0000;
        cfg_err   = 1'b1;
        issue(0, 1'b0, 32'h30, 32'h0, 32'hCAFE_0000, 1'b1, 3, g);
        drain();
        cfg_err = 1'b0;
        issue(1, 1'b1, 32'h34, 32'h9, 32'h0, 1'b0, 3, g);
        drain();
        chk("t4_err_cleared", {63'd0, rsp_err}, 64'd0);

        // Wait-state timeout after 4 stalled ACCESS cycles.
        cfg_waits = 255;
        cfg_rdata = 32'h55;
        issue(0, 1'b0, 32'h50, 32'h0, 32'h0, 1'b1, 6, g);
        repeat (4) @(negedge PCLK);
        chk("t5_still_access", {63'd0, PENABLE}, 64'd1);
        @(negedge PCLK);
        chk("t5_idle", {63'd0, PSEL}, 64'd0);
        drain();

        // Reset during ACCESS aborts without a response.
        issue(1, 1'b0, 32'h60, 32'h0, 32'h0, 1'b0, 3, g);
        @(negedge PCLK);
        chk("t6_in_access", {63'd0, PENABLE}, 64'd1);
        #2 PRESET = 1'b1;
        #1;
        chk("t6_async_psel", {63'd0, PSEL}, 64'd0);
        chk("t6_async_pen", {63'd0, PENABLE}, 64'd0);
        chk("t6_async_paddr", {32'd0, PADDR}, 64'd0);
        q.delete();
        req_write = 2'b00;
        req_addr  = {32'h44, 32'h40};
        req_valid = 2'b11;
        #1;
        chk("t6_ready_in_rst", {62'd0, req_ready}, 64'd0);
        cfg_waits = 0;
        cfg_rdata = 32'h77;
        repeat (2) begin
            @(negedge PCLK);
            chk("t6_no_rsp", {62'd0, rsp_valid}, 64'd0);
        end
        PRESET = 1'b0;
        #1;
        chk("t6_first_grant", {62'd0, req_ready}, 64'd1);
        push(2'b01, 32'h77, 1'b0, cyc + 3);
        @(negedge PCLK);
        req_valid = 2'b00;
        drain();
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
